// File: rtl/req_key_sink_pkg.sv
`default_nettype none
// ============================================================================
// Package     : req_key_pkg
// Description : Shared defaults and key type for the key-request sink.
// Revision    : 1.0 - initial release
// ============================================================================
package req_key_pkg;

  // Default geometry of the sink and its buffer.
  localparam int KEY_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 16;

  // Key as carried on the request bus at the default width.
  typedef logic [KEY_W_DEF-1:0] key_t;

  // Key that must follow k in the sequence; wraps from all-ones to zero.
  function automatic key_t next_key(input key_t k);
    return k + key_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_key_sink_if.sv
`default_nettype none
// ============================================================================
// Interface   : req_key_sink_if
// Description : Request/ack handshake from the key producer plus the
//               valid/ready output stream of buffered keys.
// Revision    : 1.0 - initial release
// ============================================================================
interface req_key_sink_if
  import req_key_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
);

  logic             req;
  logic [KEY_W-1:0] req_key;
  logic             ack;
  logic             out_valid;
  logic [KEY_W-1:0] out_key;
  logic             out_ready;

  // Environment side: offers keys and consumes the output stream.
  modport master (
    output req,
    output req_key,
    output out_ready,
    input  ack,
    input  out_valid,
    input  out_key
  );

  // Sink side: acknowledges keys and presents the buffered head.
  modport slave (
    input  req,
    input  req_key,
    input  out_ready,
    output ack,
    output out_valid,
    output out_key
  );

endinterface
`default_nettype wire

// File: rtl/req_key_sink_key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo
// Description : Synchronous FIFO, power-of-two depth, no bypass. The head
//               entry is read straight from storage, so a word written at an
//               edge becomes visible on dout right after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module key_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic      [CW-1:0]    count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage write; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);

endmodule
`default_nettype wire

// File: rtl/req_key_sink.sv
`default_nettype none
// ============================================================================
// Module      : req_key_sink
// Description : Consumer of the key-request producer. Acknowledges keys with
//               a fully registered ack, checks that keys arrive in order
//               (wrapping at 2^KEY_W), buffers them in a FIFO and presents
//               them on a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module req_key_sink
  import req_key_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  req_key_sink_if.slave         bus,
  output logic                  err,
  output logic      [KEY_W-1:0] err_key,
  input  wire logic             err_clr,
  output logic      [CNT_W-1:0] xfer_cnt
);

  localparam int            c_cw    = $clog2(DEPTH) + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  logic             r_ack;
  logic [KEY_W-1:0] r_expected;
  logic             r_err;
  logic [KEY_W-1:0] r_err_key;
  logic [CNT_W-1:0] r_xfer_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [c_cw-1:0]  w_count;
  logic [c_cw-1:0]  w_count_next;
  logic [KEY_W-1:0] w_dout;
  logic             w_mismatch;

  // ack is registered and only ever high while there is room, so the full
  // term is redundant protection against overflow rather than flow control.
  assign w_push       = bus.req && r_ack && !w_full;
  assign w_pop        = !w_empty && bus.out_ready;
  assign w_count_next = w_count + c_cw'(w_push) - c_cw'(w_pop);
  assign w_mismatch   = (bus.req_key != r_expected);

  key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KEY_W)
  ) u_key_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.req_key),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  // Grant the next transfer only if the occupancy after this edge leaves
  // room; a pop while full therefore reopens ack one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= (w_count_next < c_depth);
    end
  end

  // Track the key that must come next; resync on every push, even a bad one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_expected <= '0;
    end else if (w_push) begin
      r_expected <= bus.req_key + KEY_W'(1);
    end
  end

  // Sticky error keeping the first bad key; a new error beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_key <= '0;
    end else if (w_push && w_mismatch) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) begin
        r_err_key <= bus.req_key;
      end
    end else if (err_clr) begin
      r_err     <= 1'b0;
      r_err_key <= '0;
    end
  end

  // Free-running count of accepted transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_push) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  assign bus.ack       = r_ack;
  assign bus.out_valid = !w_empty;
  assign bus.out_key   = w_dout;
  assign err           = r_err;
  assign err_key       = r_err_key;
  assign xfer_cnt      = r_xfer_cnt;

endmodule
`default_nettype wire
